// File: rtl/recon_luma4x4.sv
// Luma 4x4 intra reconstruction: predicts one block from latched neighbours, adds a
// streamed residual with clipping and streams pixels out in raster order.
module recon_luma4x4 #(
    parameter int BITDEPTH = 8,
    parameter int RESWIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic [2:0]            mode,
    input  logic [8*BITDEPTH-1:0] top,
    input  logic [4*BITDEPTH-1:0] left,
    input  logic [BITDEPTH-1:0]   corner,
    input  logic                  res_valid,
    input  logic [RESWIDTH-1:0]   res_data,
    output logic                  res_ready,
    output logic                  pix_valid,
    output logic [BITDEPTH-1:0]   pix_data,
    input  logic                  pix_ready,
    output logic                  done,
    output logic                  busy,
    output logic [4*BITDEPTH-1:0] recon_bottom,
    output logic [4*BITDEPTH-1:0] recon_right
);

    typedef enum logic [1:0] {IDLE, PRED, RUN, DONE} state_t;

    state_t state, state_next;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // valid never waits on ready, and both are forced low while enable is low.

    // Neighbour edge, index 0..12 = L,K,J,I,M,A..H so that p[-1,y] = 3-y and p[x,-1] = 5+x.
    logic [2:0]              mode_q;
    logic [13*BITDEPTH-1:0]  edge_q;
    logic [BITDEPTH-1:0]     pred_q    [16];
    logic [BITDEPTH-1:0]     pred_comb [16];
    logic [BITDEPTH-1:0]     recon_q   [16];
    logic [4:0]              k_q;
    logic                    pix_valid_q;
    logic [BITDEPTH-1:0]     pix_data_q;

    logic                    accept;
    logic                    out_hs;
    logic signed [BITDEPTH+1:0] sum;
    logic [BITDEPTH-1:0]     recon_pix;

    function automatic logic [BITDEPTH-1:0] px(input logic [13*BITDEPTH-1:0] ev, input int i);
        logic [BITDEPTH-1:0] r;
        r = '0;
        for (int n = 0; n < 13; n++) begin
            if (n == i) r = ev[n*BITDEPTH +: BITDEPTH];
        end
        return r;
    endfunction

    function automatic logic [BITDEPTH-1:0] f2(input logic [BITDEPTH-1:0] a,
                                               input logic [BITDEPTH-1:0] b);
        logic [BITDEPTH:0] s;
        s = {1'b0, a} + {1'b0, b} + (BITDEPTH+1)'(1);
        return s[BITDEPTH:1];
    endfunction

    function automatic logic [BITDEPTH-1:0] f3(input logic [BITDEPTH-1:0] a,
                                               input logic [BITDEPTH-1:0] b,
                                               input logic [BITDEPTH-1:0] c);
        logic [BITDEPTH+1:0] s;
        s = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c} + (BITDEPTH+2)'(2);
        return s[BITDEPTH+1:2];
    endfunction

    function automatic logic [BITDEPTH-1:0] pred_px(input logic [2:0] md, input int x, input int y,
                                                    input logic [13*BITDEPTH-1:0] ev);
        logic [BITDEPTH-1:0] r;
        int z;
        int j;
        r = '0;
        z = 0;
        j = 0;
        case (md)
            3'd0: r = px(ev, 5 + x);
            3'd1: r = px(ev, 3 - y);
            3'd2: begin
                if (x == 3 && y == 3) r = f3(px(ev, 11), px(ev, 12), px(ev, 12));
                else                  r = f3(px(ev, 5 + x + y), px(ev, 6 + x + y), px(ev, 7 + x + y));
            end
            3'd3: begin
                // Diagonal down-right is a 3-tap filter centred on the edge walked through M.
                j = 4 + x - y;
                r = f3(px(ev, j - 1), px(ev, j), px(ev, j + 1));
            end
            3'd4: begin
                z = 2 * x - y;
                j = 4 + x - (y >> 1);
                if (z >= 0 && (z & 1) == 0) r = f2(px(ev, j), px(ev, j + 1));
                else if (z >= 0)            r = f3(px(ev, j - 1), px(ev, j), px(ev, j + 1));
                else if (z == -1)           r = f3(px(ev, 3), px(ev, 4), px(ev, 5));
                else                        r = f3(px(ev, 4 - y), px(ev, 5 - y), px(ev, 6 - y));
            end
            3'd5: begin
                z = 2 * y - x;
                j = 4 - y + (x >> 1);
                if (z >= 0 && (z & 1) == 0) r = f2(px(ev, j), px(ev, j - 1));
                else if (z >= 0)            r = f3(px(ev, j + 1), px(ev, j), px(ev, j - 1));
                else if (z == -1)           r = f3(px(ev, 3), px(ev, 4), px(ev, 5));
                else                        r = f3(px(ev, 4 + x), px(ev, 3 + x), px(ev, 2 + x));
            end
            3'd6: begin
                j = 5 + x + (y >> 1);
                if ((y & 1) == 0) r = f2(px(ev, j), px(ev, j + 1));
                else              r = f3(px(ev, j), px(ev, j + 1), px(ev, j + 2));
            end
            default: begin
                z = x + 2 * y;
                j = 3 - (y + (x >> 1));
                if (z > 5)                  r = px(ev, 0);
                else if (z == 5)            r = f3(px(ev, 1), px(ev, 0), px(ev, 0));
                else if ((z & 1) == 0)      r = f2(px(ev, j), px(ev, j - 1));
                else                        r = f3(px(ev, j), px(ev, j - 1), px(ev, j - 2));
            end
        endcase
        return r;
    endfunction

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            pred_comb[k] = pred_px(mode_q, k % 4, k / 4, edge_q);
        end
    end

    assign res_ready = enable && (state == RUN) && !k_q[4] && (!pix_valid_q || pix_ready);
    assign accept    = res_ready && res_valid;
    assign out_hs    = enable && pix_valid_q && pix_ready;
    assign pix_valid = enable && pix_valid_q;
    assign pix_data  = pix_data_q;
    assign done      = enable && (state == DONE);
    assign busy      = (state != IDLE);

    // Residual is sign-extended into a 10-bit sum, then clipped to the pixel range.
    always_comb begin
        sum = $signed({2'b00, pred_q[k_q[3:0]]}) + (BITDEPTH+2)'($signed(res_data));
        if (sum[BITDEPTH+1])   recon_pix = '0;
        else if (sum[BITDEPTH]) recon_pix = '1;
        else                   recon_pix = sum[BITDEPTH-1:0];
    end

    always_comb begin
        state_next = state;
        if (enable) begin
            case (state)
                IDLE:    if (start) state_next = PRED;
                PRED:    state_next = RUN;
                RUN:     if (out_hs && k_q[4]) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mode_q      <= '0;
            edge_q      <= '0;
            k_q         <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            for (int i = 0; i < 16; i++) begin
                pred_q[i]  <= '0;
                recon_q[i] <= '0;
            end
        end else if (enable) begin
            state <= state_next;
            if (state == IDLE && start) begin
                mode_q <= mode;
                edge_q <= {top, corner, left[BITDEPTH-1:0], left[2*BITDEPTH-1:BITDEPTH],
                           left[3*BITDEPTH-1:2*BITDEPTH], left[4*BITDEPTH-1:3*BITDEPTH]};
                k_q    <= '0;
            end
            if (state == PRED) pred_q <= pred_comb;
            if (accept) begin
                pix_data_q          <= recon_pix;
                pix_valid_q         <= 1'b1;
                recon_q[k_q[3:0]]   <= recon_pix;
                k_q                 <= k_q + 5'd1;
            end else if (out_hs) begin
                pix_valid_q <= 1'b0;
            end
        end
    end

    assign recon_bottom = {recon_q[15], recon_q[14], recon_q[13], recon_q[12]};
    assign recon_right  = {recon_q[15], recon_q[11], recon_q[7], recon_q[3]};

endmodule
